alu_muldiv_ctrl: RTL and testbench

ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

---
 rtl/alu_muldiv_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: ALU decode plus sequential mul/div unit owning HI/LO.
// Define MULDIV_EARLY_EXIT_EN to end a multiply once the remaining multiplier is zero.
module alu_muldiv_ctrl #(
    parameter int WIDTH  = 32,
    parameter int CONF_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        ALUOp,
    input  logic [5:0]        Funct,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CONF_W-1:0] ALUConf,
    output logic              Sign,
    output logic              out_valid,
    output logic [WIDTH-1:0]  HI,
    output logic [WIDTH-1:0]  LO,
    output logic              div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic dbz_q, dbz_d, neg_q, neg_d, rneg_q, rneg_d;
    logic [4:0] conf;
    logic accept, sa, sb, last, mul_end;
    logic [WIDTH-1:0] abs_a, abs_b, nrem, quot_fix, rem_fix;
    logic [WIDTH:0] trial;
    logic [2*WIDTH-1:0] prod, prod_fix, nacc;
    always_comb begin
        conf = 5'b00010;
        case (ALUOp[2:0])
            3'b001: conf = 5'b00110;
            3'b011: conf = 5'b00000;
            3'b100: conf = 5'b00111;
            3'b010:
                case (Funct)
                    6'h22, 6'h23: conf = 5'b00110;
                    6'h24:        conf = 5'b00000;
                    6'h25:        conf = 5'b00001;
                    6'h26:        conf = 5'b01001;
                    6'h27:        conf = 5'b01000;
                    6'h2a, 6'h2b: conf = 5'b00111;
                    6'h00:        conf = 5'b01010;
                    6'h02:        conf = 5'b10000;
                    6'h03:        conf = 5'b10001;
                    default:      conf = 5'b00010;
                endcase
            default: conf = 5'b00010;
        endcase
    end
    assign ALUConf = CONF_W'(conf);
    assign Sign = (ALUOp[2:0] == 3'b010) ? !(Funct inside {6'h21, 6'h23, 6'h2b, 6'h19, 6'h1b}) : ~ALUOp[3];
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign HI = hi_q;
    assign LO = lo_q;
    assign div_by_zero = dbz_q;
    assign accept = in_valid && in_ready && ALUOp[2:0] == 3'b010;
    assign sa = Sign & A[WIDTH-1];
    assign sb = Sign & B[WIDTH-1];
    assign abs_a = sa ? -A : A;
    assign abs_b = sb ? -B : B;
    assign last = cnt_q == CW'(WIDTH - 1);
`ifdef MULDIV_EARLY_EXIT_EN
    assign mul_end = last || mplier_q[WIDTH-1:1] == '0;
`else
    assign mul_end = last;
`endif
    assign prod = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign prod_fix = neg_q ? -prod : prod;
    // Restoring step: acc holds {remainder, dividend bits still to shift in}.
    assign trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mplier_q};
    assign nrem = trial[WIDTH] ? acc_q[2*WIDTH-2:WIDTH-1] : trial[WIDTH-1:0];
    assign nacc = {nrem, acc_q[WIDTH-2:0], ~trial[WIDTH]};
    assign quot_fix = neg_q ? -nacc[WIDTH-1:0] : nacc[WIDTH-1:0];
    assign rem_fix = rneg_q ? -nrem : nrem;
    always_comb begin
        state_d = state_q;
        hi_d = hi_q;
        lo_d = lo_q;
        acc_d = acc_q;
        mcand_d = mcand_q;
        mplier_d = mplier_q;
        cnt_d = cnt_q;
        dbz_d = dbz_q;
        neg_d = neg_q;
        rneg_d = rneg_q;
        case (state_q)
            IDLE: if (accept) begin
                hi_d = (Funct == 6'h11) ? A : hi_q;
                lo_d = (Funct == 6'h13) ? A : lo_q;
                cnt_d = '0;
                neg_d = sa ^ sb;
                rneg_d = sa;
                mplier_d = abs_b;
                mcand_d = {{WIDTH{1'b0}}, abs_a};
                acc_d = (Funct[5:1] == 5'b01101) ? {{WIDTH{1'b0}}, abs_a} : '0;
                if (Funct[5:1] == 5'b01100) state_d = MUL;
                else if (Funct[5:1] == 5'b01101 && B != '0) state_d = DIV;
                else if (Funct[5:1] == 5'b01101) begin
                    state_d = DONE;
                    hi_d = A;
                    lo_d = '1;
                    dbz_d = 1'b1;
                end
            end
            MUL: begin
                acc_d = prod;
                mcand_d = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d = cnt_q + CW'(1);
                state_d = mul_end ? DONE : MUL;
                {hi_d, lo_d} = mul_end ? prod_fix : {hi_q, lo_q};
            end
            DIV: begin
                acc_d = nacc;
                cnt_d = cnt_q + CW'(1);
                state_d = last ? DONE : DIV;
                hi_d = last ? rem_fix : hi_q;
                lo_d = last ? quot_fix : lo_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            hi_q <= '0;
            lo_q <= '0;
            acc_q <= '0;
            mcand_q <= '0;
            mplier_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
            neg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            acc_q <= acc_d;
            mcand_q <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q <= cnt_d;
            dbz_q <= dbz_d;
            neg_q <= neg_d;
            rneg_q <= rneg_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb_alu_muldiv_ctrl: directed checks of decode, mul/div results, latency, reset.
module tb_alu_muldiv_ctrl;
    logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
    logic [3:0] ALUOp = '0;
    logic [5:0] Funct = '0;
    logic [31:0] A = '0, B = '0;
    logic in_ready, Sign, out_valid, div_by_zero;
    logic [4:0] ALUConf;
    logic [31:0] HI, LO;
    int checks = 0, errors = 0;
    int lat;
    logic rdy, seen;
    alu_muldiv_ctrl dut (
        .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct(Funct), .A(A), .B(B),
        .in_valid(in_valid), .in_ready(in_ready), .ALUConf(ALUConf), .Sign(Sign),
        .out_valid(out_valid), .HI(HI), .LO(LO), .div_by_zero(div_by_zero)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic int mul_cycles(input logic [31:0] mag);
        int n = 32;
`ifdef MULDIV_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
`endif
        return n;
    endfunction
    task automatic dec(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] c, input logic s);
        ALUOp = op;
        Funct = fn;
        #1;
        chk($sformatf("conf_%h_%h", op, fn), ALUConf, c);
        chk($sformatf("sign_%h_%h", op, fn), Sign, s);
    endtask
    task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output int l, output logic r);
        @(negedge clk);
        ALUOp = 4'b0010; Funct = fn; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = 32'h5a5a_a5a5; B = 32'h0000_0003;
        l = 1; r = 1'b0;
        while (!out_valid && l < 100) begin
            r |= in_ready;
            @(posedge clk); #1;
            l++;
        end
        r |= in_ready;
        @(posedge clk); #1;
        chk("pulse_end", out_valid, 1'b0);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_dbz", div_by_zero, 0);
        reset = 1'b1;
        dec(4'b0010, 6'h2b, 5'b00111, 0);
        dec(4'b1011, 6'h00, 5'b00000, 0);
        dec(4'b0010, 6'h3f, 5'b00010, 1);
        dec(4'b0000, 6'h00, 5'b00010, 1);
        dec(4'b0001, 6'h00, 5'b00110, 1);
        dec(4'b1100, 6'h00, 5'b00111, 0);
        dec(4'b0010, 6'h27, 5'b01000, 1);
        dec(4'b0010, 6'h26, 5'b01001, 1);
        dec(4'b0010, 6'h03, 5'b10001, 1);
        dec(4'b0010, 6'h02, 5'b10000, 1);
        dec(4'b0010, 6'h00, 5'b01010, 1);
        dec(4'b0010, 6'h21, 5'b00010, 0);
        dec(4'b0010, 6'h19, 5'b00010, 0);
        // mthi / mtlo
        @(negedge clk);
        ALUOp = 4'b0010; Funct = 6'h11; A = 32'h1111_2222; in_valid = 1'b1;
        @(posedge clk); #1;
        Funct = 6'h13; A = 32'h3333_4444;
        chk("mthi", HI, 32'h1111_2222);
        chk("mthi_ov", out_valid, 0);
        chk("mthi_rdy", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mtlo", LO, 32'h3333_4444);
        chk("mtlo_hi", HI, 32'h1111_2222);
        // non-R op is not accepted
        @(negedge clk);
        ALUOp = 4'b0000; Funct = 6'h18; A = 32'h2; B = 32'h2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("nonr_rdy", in_ready, 1);
        run_op(6'h18, 32'hffff_ffff, 32'h7, lat, rdy);
        chk("mult_lat", lat, mul_cycles(7) + 1);
        chk("mult_hi", HI, 32'hffff_ffff);
        chk("mult_lo", LO, 32'hffff_fff9);
        chk("mult_busy", rdy, 0);
        run_op(6'h1b, 32'd100, 32'd7, lat, rdy);
        chk("divu_lat", lat, 33);
        chk("divu_lo", LO, 32'h0000_000e);
        chk("divu_hi", HI, 32'h0000_0002);
        chk("divu_dbz", div_by_zero, 0);
        run_op(6'h1a, 32'hffff_ff9c, 32'd7, lat, rdy);
        chk("div_lo", LO, 32'hffff_fff2);
        chk("div_hi", HI, 32'hffff_fffe);
        run_op(6'h1a, 32'h8000_0000, 32'hffff_ffff, lat, rdy);
        chk("ovf_lo", LO, 32'h8000_0000);
        chk("ovf_hi", HI, 32'h0);
        chk("ovf_dbz", div_by_zero, 0);
        run_op(6'h19, 32'hffff_ffff, 32'hffff_ffff, lat, rdy);
        chk("multu_max", {HI, LO}, 64'hffff_fffe_0000_0001);
        run_op(6'h1a, 32'h1234_5678, 32'h0, lat, rdy);
        chk("dbz_lat", lat, 1);
        chk("dbz_hi", HI, 32'h1234_5678);
        chk("dbz_lo", LO, 32'hffff_ffff);
        chk("dbz_flag", div_by_zero, 1);
        run_op(6'h1b, 32'd9, 32'd2, lat, rdy);
        chk("dbz_sticky", div_by_zero, 1);
        chk("divu9_lo", LO, 32'd4);
        // mthi while busy must be ignored
        @(negedge clk);
        ALUOp = 4'b0010; Funct = 6'h1b; A = 32'd50; B = 32'd8; in_valid = 1'b1;
        @(posedge clk); #1;
        Funct = 6'h11; A = 32'hdead_beef;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_ign_hi", HI, 32'd2);
        chk("busy_ign_lo", LO, 32'd6);
        @(posedge clk); #1;
        // reset mid-multiply
        @(negedge clk);
        ALUOp = 4'b0010; Funct = 6'h19; A = 32'hffff; B = 32'hffff; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("abort_hi", HI, 0);
        chk("abort_lo", LO, 0);
        chk("abort_rdy", in_ready, 1);
        chk("abort_dbz", div_by_zero, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        chk("abort_no_ov", seen, 0);
        run_op(6'h19, 32'd3, 32'd5, lat, rdy);
        chk("multu_lat", lat, mul_cycles(5) + 1);
        chk("multu_lo", LO, 32'h0000_000f);
        chk("multu_hi", HI, 32'h0);
        run_op(6'h19, 32'd9, 32'd5, lat, rdy);
        chk("m95_lat", lat, mul_cycles(5) + 1);
        chk("m95_lo", LO, 32'h0000_002d);
        run_op(6'h19, 32'd9, 32'd0, lat, rdy);
        chk("m90_lat", lat, mul_cycles(0) + 1);
        chk("m90_lo", LO, 32'h0);
        // reset wins over a same-cycle accept
        @(negedge clk);
        ALUOp = 4'b0010; Funct = 6'h11; A = 32'hcafe_f00d; in_valid = 1'b1; reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0;
        chk("rst_prio_hi", HI, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
